mem_burst_responder: RTL and testbench

- Memory-side responder for the cache's 128-bit memory request/response interface; the other end of the cache's mem_req_*/mem_resp_* ports.
- Serves 4-beat line reads (512-bit line = 4 x 128-bit beats) and single-beat masked writes from a backing store.
- Read and write latency are programmable, so cache miss and writeback paths can be exercised with realistic stalls in simulation and FPGA bring-up.

---
 rtl/mem_burst_responder_pkg.sv | 26 ++
 rtl/mem_burst_responder_if.sv | 47 ++++
 rtl/mem_byte_store.sv | 34 +++
 rtl/mem_burst_responder.sv | 166 ++++++++++++++++
 tb/tb_mem_burst_responder.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_burst_responder_pkg.sv
// Shared definitions for the memory burst responder: FSM state encoding,
// default latencies and small elaboration-time helpers.
package mem_burst_responder_pkg;

    localparam int MEM_DATA_BITS         = 128;
    localparam int DEFAULT_BURST_LEN     = 4;
    localparam int DEFAULT_READ_LATENCY  = 4;
    localparam int DEFAULT_WRITE_LATENCY = 2;

    typedef enum logic [1:0] {
        RESP_IDLE     = 2'd0,
        RESP_RD_WAIT  = 2'd1,
        RESP_RD_BURST = 2'd2,
        RESP_WR_BUSY  = 2'd3
    } resp_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int width_for(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_burst_responder_if.sv
// Cache-to-memory request/response bundle. The master side is the cache,
// the slave side is the memory responder.
interface mem_burst_responder_if
    import mem_burst_responder_pkg::*;
#(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = MEM_DATA_BITS
);

    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [ADDR_BITS-1:0]   mem_req_addr;
    logic                   mem_req_rw;
    logic                   mem_req_data_valid;
    logic                   mem_req_data_ready;
    logic [DATA_BITS-1:0]   mem_req_data_bits;
    logic [DATA_BITS/8-1:0] mem_req_data_mask;
    logic                   mem_resp_valid;
    logic [DATA_BITS-1:0]   mem_resp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        output mem_req_rw,
        output mem_req_data_valid,
        output mem_req_data_bits,
        output mem_req_data_mask,
        input  mem_req_ready,
        input  mem_req_data_ready,
        input  mem_resp_valid,
        input  mem_resp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        input  mem_req_rw,
        input  mem_req_data_valid,
        input  mem_req_data_bits,
        input  mem_req_data_mask,
        output mem_req_ready,
        output mem_req_data_ready,
        output mem_resp_valid,
        output mem_resp_data
    );

endinterface

// File: rtl/mem_byte_store.sv
// Backing store: 2**DEPTH_LOG2 words of DATA_BITS, synchronous byte-masked
// write, asynchronous read. Contents are intentionally not reset.
module mem_byte_store #(
    parameter int DEPTH_LOG2 = 12,
    parameter int DATA_BITS  = 128
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [DEPTH_LOG2-1:0]  waddr,
    input  logic [DATA_BITS-1:0]   wdata,
    input  logic [DATA_BITS/8-1:0] wmask,
    input  logic [DEPTH_LOG2-1:0]  raddr,
    output logic [DATA_BITS-1:0]   rdata
);

    localparam int NBYTES = DATA_BITS / 8;
    localparam int DEPTH  = 2 ** DEPTH_LOG2;

    logic [DATA_BITS-1:0] mem [DEPTH];

    // Byte-granular write: only lanes with their enable set are updated.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (wmask[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_burst_responder.sv
// Memory-side responder: wrapping line-read bursts and single-beat masked
// writes against mem_byte_store, with programmable read/write latency.
module mem_burst_responder
    import mem_burst_responder_pkg::*;
#(
    parameter int ADDR_BITS     = 28,
    parameter int DATA_BITS     = MEM_DATA_BITS,
    parameter int DEPTH_LOG2    = 12,
    parameter int BURST_LEN     = DEFAULT_BURST_LEN,
    parameter int READ_LATENCY  = DEFAULT_READ_LATENCY,
    parameter int WRITE_LATENCY = DEFAULT_WRITE_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    mem_burst_responder_if.slave bus
);

    localparam int BEAT_W = width_for(BURST_LEN);
    localparam int LAT_W  = $clog2(max_int(READ_LATENCY, WRITE_LATENCY) + 1);

    localparam logic [LAT_W-1:0]      RD_LOAD   = LAT_W'(READ_LATENCY - 1);
    localparam logic [LAT_W-1:0]      WR_LOAD   = LAT_W'(WRITE_LATENCY);
    localparam logic [LAT_W-1:0]      LAT_ONE   = LAT_W'(1);
    localparam logic [BEAT_W-1:0]     BEAT_ONE  = BEAT_W'(1);
    localparam logic [BEAT_W-1:0]     BEAT_WRAP = BEAT_W'(BURST_LEN - 1);
    localparam logic [DEPTH_LOG2-1:0] LINE_LO   = DEPTH_LOG2'(BURST_LEN - 1);

    resp_state_e            state_q, state_d;
    logic [LAT_W-1:0]       lat_q, lat_d;
    logic [BEAT_W-1:0]      beat_q, beat_d, beat_pre;
    logic [DEPTH_LOG2-1:0]  addr_q, addr_d;
    logic                   resp_valid_q;
    logic [DATA_BITS-1:0]   resp_data_q;

    logic                   ready;
    logic                   rd_accept;
    logic                   wr_accept;
    logic                   issue;
    logic [DEPTH_LOG2-1:0]  req_index;
    logic [DEPTH_LOG2-1:0]  rd_index;
    logic [DATA_BITS-1:0]   rd_data;
    logic                   unused_addr_hi;

    assign ready     = (state_q == RESP_IDLE) && reset;
    assign rd_accept = bus.mem_req_valid && ready && !bus.mem_req_rw;
    assign wr_accept = bus.mem_req_valid && ready && bus.mem_req_rw && bus.mem_req_data_valid;
    assign req_index = bus.mem_req_addr[DEPTH_LOG2-1:0];

    // Upper address bits alias onto the store.
    assign unused_addr_hi = ^bus.mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];

    assign bus.mem_req_ready      = ready;
    assign bus.mem_req_data_ready = ready && bus.mem_req_rw;
    assign bus.mem_resp_valid     = resp_valid_q;
    assign bus.mem_resp_data      = resp_data_q;

    // Beat index wraps inside the line so a critical-word-first address
    // still returns the whole line; the line base bits stay fixed.
    assign rd_index = (addr_d & ~LINE_LO) | ((addr_d + DEPTH_LOG2'(beat_pre)) & LINE_LO);

    mem_byte_store #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_BITS  (DATA_BITS)
    ) u_store (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (req_index),
        .wdata (bus.mem_req_data_bits),
        .wmask (bus.mem_req_data_mask),
        .raddr (rd_index),
        .rdata (rd_data)
    );

    // Next-state, counter and beat-issue decode.
    // A beat is issued on every edge that lands in RD_BURST; the beat
    // counter counts issued beats, so wrapping back to zero while in
    // RD_BURST means the final beat is already on the output.
    // rd_index is derived from next-state values, which is the address an
    // SRAM macro would need one cycle early.
    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        beat_d   = beat_q;
        beat_pre = beat_q;
        addr_d   = addr_q;
        issue    = 1'b0;
        case (state_q)
            RESP_IDLE: begin
                if (rd_accept) begin
                    addr_d   = req_index;
                    beat_pre = '0;
                    beat_d   = '0;
                    if (READ_LATENCY == 1) begin
                        state_d = RESP_RD_BURST;
                        issue   = 1'b1;
                    end else begin
                        state_d = RESP_RD_WAIT;
                        lat_d   = RD_LOAD;
                    end
                end else if (wr_accept && (WRITE_LATENCY != 0)) begin
                    state_d = RESP_WR_BUSY;
                    lat_d   = WR_LOAD;
                end
            end
            RESP_RD_WAIT: begin
                if (lat_q <= LAT_ONE) begin
                    state_d = RESP_RD_BURST;
                    lat_d   = '0;
                    issue   = 1'b1;
                end else begin
                    lat_d = lat_q - LAT_ONE;
                end
            end
            RESP_RD_BURST: begin
                if ((beat_q & BEAT_WRAP) == '0) begin
                    state_d = RESP_IDLE;
                end else begin
                    issue = 1'b1;
                end
            end
            RESP_WR_BUSY: begin
                if (lat_q <= LAT_ONE) begin
                    state_d = RESP_IDLE;
                    lat_d   = '0;
                end else begin
                    lat_d = lat_q - LAT_ONE;
                end
            end
            default: begin
                state_d = RESP_IDLE;
            end
        endcase
        if (issue) begin
            beat_d = beat_pre + BEAT_ONE;
        end
    end

    // State, counters and latched line address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RESP_IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
        end
    end

    // Registered response; data holds its last beat when not valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= issue;
            if (issue) begin
                resp_data_q <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_burst_responder.sv
// Bench for mem_burst_responder: two instances (latency 4/2 and 1/0) checked
// every cycle against a transaction-level model, plus literal expectations.
module tb_mem_burst_responder;

    localparam logic [127:0] PA = {4{32'hA0A0_0001}};
    localparam logic [127:0] PB = {4{32'hB0B0_0002}};
    localparam logic [127:0] PC = {4{32'hC0C0_0003}};
    localparam logic [127:0] PD = {4{32'hD0D0_0004}};
    localparam logic [127:0] PE = {4{32'hE0E0_0005}};
    localparam logic [127:0] PF = {4{32'hF0F0_0006}};
    localparam logic [127:0] MASKED_BEAT = 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic         req_valid [2];
    logic         req_rw    [2];
    logic         req_dv    [2];
    logic [27:0]  req_addr  [2];
    logic [127:0] req_data  [2];
    logic [15:0]  req_mask  [2];
    logic         rdy  [2];
    logic         drdy [2];
    logic         rv   [2];
    logic [127:0] rd   [2];

    mem_burst_responder_if #(.ADDR_BITS(28), .DATA_BITS(128)) bus_a ();
    mem_burst_responder_if #(.ADDR_BITS(28), .DATA_BITS(128)) bus_b ();

    assign bus_a.mem_req_valid      = req_valid[0];
    assign bus_a.mem_req_rw         = req_rw[0];
    assign bus_a.mem_req_addr       = req_addr[0];
    assign bus_a.mem_req_data_valid = req_dv[0];
    assign bus_a.mem_req_data_bits  = req_data[0];
    assign bus_a.mem_req_data_mask  = req_mask[0];
    assign rdy[0]  = bus_a.mem_req_ready;
    assign drdy[0] = bus_a.mem_req_data_ready;
    assign rv[0]   = bus_a.mem_resp_valid;
    assign rd[0]   = bus_a.mem_resp_data;

    assign bus_b.mem_req_valid      = req_valid[1];
    assign bus_b.mem_req_rw         = req_rw[1];
    assign bus_b.mem_req_addr       = req_addr[1];
    assign bus_b.mem_req_data_valid = req_dv[1];
    assign bus_b.mem_req_data_bits  = req_data[1];
    assign bus_b.mem_req_data_mask  = req_mask[1];
    assign rdy[1]  = bus_b.mem_req_ready;
    assign drdy[1] = bus_b.mem_req_data_ready;
    assign rv[1]   = bus_b.mem_resp_valid;
    assign rd[1]   = bus_b.mem_resp_data;

    mem_burst_responder #(
        .ADDR_BITS(28), .DATA_BITS(128), .DEPTH_LOG2(12), .BURST_LEN(4),
        .READ_LATENCY(4), .WRITE_LATENCY(2)
    ) dut_a (.clk(clk), .reset(reset), .bus(bus_a));

    mem_burst_responder #(
        .ADDR_BITS(28), .DATA_BITS(128), .DEPTH_LOG2(12), .BURST_LEN(4),
        .READ_LATENCY(1), .WRITE_LATENCY(0)
    ) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    // ---------------- transaction-level model ----------------
    int           rl_m [2] = '{4, 1};
    int           wl_m [2] = '{2, 0};
    logic [127:0] mem_m [2][4096];
    int           q_cyc [2][$];
    logic [127:0] q_dat [2][$];
    logic [127:0] last_m [2];
    int           busy_m [2];
    logic [127:0] got [4];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison, then model update for a handshake in this cycle.
    always @(negedge clk) begin
        string        p;
        logic         ev;
        logic [127:0] ed;
        logic         er;
        int           idx;
        int           base;
        for (int d = 0; d < 2; d++) begin
            p = (d == 0) ? "a_" : "b_";
            if (!reset) begin
                q_cyc[d].delete();
                q_dat[d].delete();
                last_m[d] = '0;
                busy_m[d] = 0;
                chk({p, "rst_ready"}, 128'(rdy[d]), 128'(0));
                chk({p, "rst_valid"}, 128'(rv[d]), 128'(0));
                chk({p, "rst_data"}, rd[d], 128'(0));
            end else begin
                er = (cyc >= busy_m[d]);
                ev = 1'b0;
                ed = last_m[d];
                if (q_cyc[d].size() > 0 && q_cyc[d][0] == cyc) begin
                    ev = 1'b1;
                    ed = q_dat[d].pop_front();
                    void'(q_cyc[d].pop_front());
                    last_m[d] = ed;
                end
                chk({p, "ready"}, 128'(rdy[d]), 128'(er));
                chk({p, "data_ready"}, 128'(drdy[d]), 128'(er && req_rw[d]));
                chk({p, "resp_valid"}, 128'(rv[d]), 128'(ev));
                chk({p, "resp_data"}, rd[d], ed);
                if (er && req_valid[d]) begin
                    idx = int'(req_addr[d][11:0]);
                    if (!req_rw[d]) begin
                        base = idx & ~3;
                        for (int k = 0; k < 4; k++) begin
                            q_cyc[d].push_back(cyc + rl_m[d] + k);
                            q_dat[d].push_back(mem_m[d][base | ((idx + k) & 3)]);
                        end
                        busy_m[d] = cyc + rl_m[d] + 4;
                    end else if (req_dv[d]) begin
                        for (int b = 0; b < 16; b++) begin
                            if (req_mask[d][b]) mem_m[d][idx][8*b +: 8] = req_data[d][8*b +: 8];
                        end
                        busy_m[d] = cyc + wl_m[d] + 1;
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    // Present a request; returns the cycle whose closing edge accepted it.
    task automatic issue(input int d, input logic rw, input logic [27:0] a,
                         input logic [127:0] wd, input logic [15:0] m,
                         input int dv_delay, output int acc);
        int start;
        bit done;
        req_valid[d] = 1'b1;
        req_rw[d]    = rw;
        req_addr[d]  = a;
        req_data[d]  = wd;
        req_mask[d]  = m;
        req_dv[d]    = rw && (dv_delay == 0);
        start = cyc;
        acc   = -1;
        done  = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (rdy[d] && (!rw || req_dv[d])) begin
                acc  = cyc;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!done && rw && (cyc - start >= dv_delay)) req_dv[d] = 1'b1;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL handshake_timeout: got no accept expected accept within 64 cycles");
        end
        req_valid[d] = 1'b0;
        req_dv[d]    = 1'b0;
        req_rw[d]    = 1'b0;
    endtask

    // Capture four beats; first = cycle of the first valid beat.
    task automatic collect(input int d, output int first);
        first = -1;
        for (int i = 0; i < 32 && first < 0; i++) begin
            @(negedge clk);
            if (rv[d]) first = cyc;
        end
        if (first < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_timeout: got no beat expected beat within 32 cycles");
        end else begin
            got[0] = rd[d];
            for (int k = 1; k < 4; k++) begin
                @(negedge clk);
                got[k] = rd[d];
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int acc, racc, first, s;
        logic [127:0] line [4];
        line[0] = PA; line[1] = PB; line[2] = PC; line[3] = PD;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_rw[d] = 1'b0; req_dv[d] = 1'b0;
            req_addr[d] = '0; req_data[d] = '0; req_mask[d] = '0;
        end
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("a_ready_after_reset", 128'(rdy[0]), 128'(1));
        chk("b_ready_after_reset", 128'(rdy[1]), 128'(1));

        // Preload line 0x40 on A; first write pins the 2-cycle busy window.
        for (int k = 0; k < 4; k++) begin
            issue(0, 1'b1, 28'h40 + 28'(k), line[k], 16'hFFFF, 0, acc);
            if (k == 0) begin
                chk("a_wr_busy1", 128'(rdy[0]), 128'(0));
                @(posedge clk); #1;
                chk("a_wr_busy2", 128'(rdy[0]), 128'(0));
                @(posedge clk); #1;
                chk("a_wr_done", 128'(rdy[0]), 128'(1));
            end
        end

        // Aligned read: latency 4, beats A,B,C,D, ready back right after.
        issue(0, 1'b0, 28'h40, '0, '0, 0, acc);
        collect(0, first);
        chk("a_first_beat_latency", 128'(first - acc), 128'(4));
        chk("a_aligned_b0", got[0], PA);
        chk("a_aligned_b1", got[1], PB);
        chk("a_aligned_b2", got[2], PC);
        chk("a_aligned_b3", got[3], PD);
        chk("a_ready_after_burst", 128'(rdy[0]), 128'(1));

        // Critical-word-first wrap.
        issue(0, 1'b0, 28'h42, '0, '0, 0, acc);
        collect(0, first);
        chk("a_wrap_b0", got[0], PC);
        chk("a_wrap_b1", got[1], PD);
        chk("a_wrap_b2", got[2], PA);
        chk("a_wrap_b3", got[3], PB);

        // Aliasing: writes at 0x308x land on line 0x80, read via 0x1082.
        for (int k = 0; k < 4; k++) issue(0, 1'b1, 28'h3080 + 28'(k), line[3-k], 16'hFFFF, 0, acc);
        issue(0, 1'b0, 28'h1082, '0, '0, 0, acc);
        collect(0, first);
        chk("a_alias_b0", got[0], PB);
        chk("a_alias_b3", got[3], PC);

        // Masked write onto a zeroed word.
        issue(0, 1'b1, 28'h41, '0, 16'hFFFF, 0, acc);
        issue(0, 1'b1, 28'h41, '1, 16'h000F, 0, acc);
        issue(0, 1'b0, 28'h40, '0, '0, 0, acc);
        collect(0, first);
        chk("a_masked_b0", got[0], PA);
        chk("a_masked_b1", got[1], MASKED_BEAT);
        chk("a_masked_b2", got[2], PC);

        // Write data held back three cycles: accepted on the fourth edge.
        s = cyc;
        issue(0, 1'b1, 28'h43, PE, 16'hFFFF, 3, acc);
        chk("a_dv_delay_accept", 128'(acc - s), 128'(3));
        @(posedge clk); #1;
        @(posedge clk); #1;
        issue(0, 1'b0, 28'h40, '0, '0, 0, acc);
        collect(0, first);
        chk("a_dv_delay_data", got[3], PE);

        // B (latency 1/0): preload, then write and read on consecutive edges.
        for (int k = 0; k < 4; k++) issue(1, 1'b1, 28'h10 + 28'(k), line[k], 16'hFFFF, 0, acc);
        issue(1, 1'b1, 28'h10, PF, 16'hFFFF, 0, acc);
        issue(1, 1'b0, 28'h10, '0, '0, 0, racc);
        chk("b_back_to_back", 128'(racc - acc), 128'(1));
        collect(1, first);
        chk("b_first_beat_latency", 128'(first - racc), 128'(1));
        chk("b_raw_b0", got[0], PF);
        chk("b_raw_b1", got[1], PB);
        issue(1, 1'b0, 28'h13, '0, '0, 0, racc);
        collect(1, first);
        chk("b_wrap_b0", got[0], PD);
        chk("b_wrap_b1", got[1], PF);

        // Reset while beat 1 of an A burst is on the bus.
        issue(0, 1'b0, 28'h40, '0, '0, 0, acc);
        repeat (4) @(posedge clk);
        #1;
        chk("a_beat1_before_reset", 128'(rv[0]), 128'(1));
        reset = 1'b0;
        #1;
        chk("a_valid_drop_on_reset", 128'(rv[0]), 128'(0));
        chk("a_ready_low_in_reset", 128'(rdy[0]), 128'(0));
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("a_ready_after_release", 128'(rdy[0]), 128'(1));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("a_no_beat_after_reset", 128'(rv[0]), 128'(0));
        end
        @(posedge clk); #1;

        // Store survives reset.
        issue(0, 1'b0, 28'h40, '0, '0, 0, acc);
        collect(0, first);
        chk("a_store_kept_b0", got[0], PA);
        chk("a_store_kept_b3", got[3], PE);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
